// File: rtl/flp_subtractor.sv
// flp_subtractor: multi-cycle |A - B| on (exp, mant) floating-point operands.
// Aligns, subtracts and normalizes iteratively behind valid/ready handshakes.
module flp_subtractor #(
    parameter int EXP_WIDTH  = 9,
    parameter int MANT_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [EXP_WIDTH-1:0]  exp1,
    input  logic [MANT_WIDTH-1:0] mant1,
    input  logic [EXP_WIDTH-1:0]  exp2,
    input  logic [MANT_WIDTH-1:0] mant2,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [EXP_WIDTH-1:0]  exp,
    output logic [MANT_WIDTH-1:0] mant,
    output logic                  sign,
    output logic                  zero
);

    typedef enum logic [2:0] {
        IDLE,
        ALIGN,
        SUB,
        NORM,
        DONE
    } state_t;

    state_t                state_q, state_d;
    logic [EXP_WIDTH-1:0]  ea_q, ea_d;
    logic [EXP_WIDTH-1:0]  eb_q, eb_d;
    logic [MANT_WIDTH-1:0] ma_q, ma_d;
    logic [MANT_WIDTH-1:0] mb_q, mb_d;
    logic [EXP_WIDTH-1:0]  max_q, max_d;
    logic [EXP_WIDTH-1:0]  exp_q, exp_d;
    logic [MANT_WIDTH-1:0] mant_q, mant_d;
    logic                  sign_q, sign_d;
    logic                  zero_q, zero_d;

    logic                  a_ge;
    logic [EXP_WIDTH-1:0]  ediff;
    logic                  far;
    logic [MANT_WIDTH-1:0] a_al;
    logic [MANT_WIDTH-1:0] b_al;

    // Alignment: shift the smaller-exponent mantissa right, flush when too far
    always_comb begin
        a_ge  = (ea_q >= eb_q);
        ediff = a_ge ? (ea_q - eb_q) : (eb_q - ea_q);
        far   = (ediff >= EXP_WIDTH'(MANT_WIDTH));
        a_al  = ma_q;
        b_al  = mb_q;
        if (a_ge) begin
            b_al = far ? '0 : (mb_q >> ediff);
        end else begin
            a_al = far ? '0 : (ma_q >> ediff);
        end
    end

    // Next-state and datapath updates for the align/sub/normalize sequence
    always_comb begin
        state_d = state_q;
        ea_d    = ea_q;
        eb_d    = eb_q;
        ma_d    = ma_q;
        mb_d    = mb_q;
        max_d   = max_q;
        exp_d   = exp_q;
        mant_d  = mant_q;
        sign_d  = sign_q;
        zero_d  = zero_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    ea_d    = exp1;
                    ma_d    = mant1;
                    eb_d    = exp2;
                    mb_d    = mant2;
                    sign_d  = 1'b0;
                    zero_d  = 1'b0;
                    state_d = ALIGN;
                end
            end
            ALIGN: begin
                ma_d    = a_al;
                mb_d    = b_al;
                max_d   = a_ge ? ea_q : eb_q;
                state_d = SUB;
            end
            SUB: begin
                if (mb_q > ma_q) begin
                    sign_d = 1'b1;
                    mant_d = mb_q - ma_q;
                end else begin
                    sign_d = 1'b0;
                    mant_d = ma_q - mb_q;
                end
                exp_d   = max_q;
                state_d = NORM;
            end
            NORM: begin
                if (mant_q == '0) begin
                    exp_d   = '0;
                    sign_d  = 1'b0;
                    zero_d  = 1'b1;
                    state_d = DONE;
                end else if (mant_q[MANT_WIDTH-1] || (exp_q == '0)) begin
                    // exponent floor leaves the result unnormalized
                    state_d = DONE;
                end else begin
                    mant_d = mant_q << 1;
                    exp_d  = exp_q - EXP_WIDTH'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ea_q    <= '0;
            eb_q    <= '0;
            ma_q    <= '0;
            mb_q    <= '0;
            max_q   <= '0;
            exp_q   <= '0;
            mant_q  <= '0;
            sign_q  <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ea_q    <= ea_d;
            eb_q    <= eb_d;
            ma_q    <= ma_d;
            mb_q    <= mb_d;
            max_q   <= max_d;
            exp_q   <= exp_d;
            mant_q  <= mant_d;
            sign_q  <= sign_d;
            zero_q  <= zero_d;
        end
    end

    // Handshake flags and result outputs come straight from registers
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        exp       = exp_q;
        mant      = mant_q;
        sign      = sign_q;
        zero      = zero_q;
    end

endmodule

// File: tb/tb_flp_subtractor.sv
// tb_flp_subtractor: scoreboard bench for flp_subtractor.
// Expected results are queued at stimulus time and popped at each output.
module tb_flp_subtractor;

    localparam int EW = 9;
    localparam int MW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [EW-1:0] exp1;
    logic [MW-1:0] mant1;
    logic [EW-1:0] exp2;
    logic [MW-1:0] mant2;
    logic          out_valid;
    logic          out_ready;
    logic [EW-1:0] exp_o;
    logic [MW-1:0] mant_o;
    logic          sign;
    logic          zero;

    typedef struct {
        logic [EW-1:0] e;
        logic [MW-1:0] m;
        logic          s;
        logic          z;
        int            lat;
    } res_t;

    res_t sb[$];
    int   errors = 0;
    int   checks = 0;

    flp_subtractor #(.EXP_WIDTH(EW), .MANT_WIDTH(MW)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .exp1(exp1),
        .mant1(mant1),
        .exp2(exp2),
        .mant2(mant2),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .exp(exp_o),
        .mant(mant_o),
        .sign(sign),
        .zero(zero)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Reference: align, subtract, then normalize by leading-zero count
    function automatic res_t model(input logic [EW-1:0] e1, input logic [MW-1:0] m1,
                                   input logic [EW-1:0] e2, input logic [MW-1:0] m2);
        res_t r;
        logic [EW-1:0] emax;
        logic [EW-1:0] d;
        logic [MW-1:0] sa;
        logic [MW-1:0] sbv;
        logic [MW-1:0] df;
        int lz;
        int k;
        if (e1 >= e2) begin
            emax = e1;
            d    = e1 - e2;
            sa   = m1;
            sbv  = (d >= 9'd8) ? 8'd0 : (m2 >> d);
        end else begin
            emax = e2;
            d    = e2 - e1;
            sbv  = m2;
            sa   = (d >= 9'd8) ? 8'd0 : (m1 >> d);
        end
        r.s = (sbv > sa);
        df  = r.s ? (sbv - sa) : (sa - sbv);
        if (df == 8'd0) begin
            r.e = '0;
            r.m = '0;
            r.s = 1'b0;
            r.z = 1'b1;
            r.lat = 4;
        end else begin
            lz = 0;
            while (df[7 - lz] == 1'b0) lz++;
            k = (lz < int'(emax)) ? lz : int'(emax);
            r.m = df << k;
            r.e = emax - EW'(k);
            r.z = 1'b0;
            r.lat = 4 + k;
        end
        return r;
    endfunction

    // Present operands and hold them until the handshake edge
    task automatic send(input logic [EW-1:0] e1, input logic [MW-1:0] m1,
                        input logic [EW-1:0] e2, input logic [MW-1:0] m2);
        int n;
        exp1 = e1;
        mant1 = m1;
        exp2 = e2;
        mant2 = m2;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            $display("FAIL accept: in_ready stuck at %b, required 1", in_ready);
            $fatal(1);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Wait for out_valid, returning its cycle index (-1 on timeout)
    task automatic wait_out(output int lat);
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!out_valid) lat = -1;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        exp1 = '0;
        mant1 = '0;
        exp2 = '0;
        mant2 = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_hs: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
        end
        checks++;
        if (exp_o !== 9'd0 || mant_o !== 8'd0 || sign !== 1'b0 || zero !== 1'b0) begin
            errors++;
            $display("FAIL reset_out: exp=%0d mant=%h sign=%b zero=%b, required all 0",
                     exp_o, mant_o, sign, zero);
        end
    endtask

    task automatic test_vectors();
        logic [EW-1:0] te1[5] = '{9'd10, 9'd5, 9'd12, 9'd20, 9'd2};
        logic [MW-1:0] tm1[5] = '{8'hC0, 8'h80, 8'hA5, 8'h90, 8'h81};
        logic [EW-1:0] te2[5] = '{9'd10, 9'd7, 9'd12, 9'd3, 9'd2};
        logic [MW-1:0] tm2[5] = '{8'h80, 8'h80, 8'hA5, 8'hFF, 8'h80};
        logic [EW-1:0] xe[5]  = '{9'd9, 9'd6, 9'd0, 9'd20, 9'd0};
        logic [MW-1:0] xm[5]  = '{8'h80, 8'hC0, 8'h00, 8'h90, 8'h04};
        logic          xs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic          xz[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        int            xl[5]  = '{5, 5, 4, 4, 6};
        res_t e;
        int lat;
        for (int i = 0; i < 5; i++) begin
            e.e = xe[i];
            e.m = xm[i];
            e.s = xs[i];
            e.z = xz[i];
            e.lat = xl[i];
            send(te1[i], tm1[i], te2[i], tm2[i]);
            sb.push_back(e);
            wait_out(lat);
            e = sb.pop_front();
            checks++;
            if (lat !== e.lat) begin
                errors++;
                $display("FAIL vec%0d_latency: got %0d, required %0d", i, lat, e.lat);
            end
            checks++;
            if (exp_o !== e.e || mant_o !== e.m || sign !== e.s || zero !== e.z) begin
                errors++;
                $display("FAIL vec%0d_result: got e=%0d m=%h s=%b z=%b, required e=%0d m=%h s=%b z=%b",
                         i, exp_o, mant_o, sign, zero, e.e, e.m, e.s, e.z);
            end
            consume();
        end
    endtask

    task automatic test_random();
        logic [EW-1:0] e1;
        logic [EW-1:0] e2;
        logic [MW-1:0] m1;
        logic [MW-1:0] m2;
        res_t e;
        int lat;
        for (int i = 0; i < 30; i++) begin
            e1 = EW'($urandom_range(0, 14));
            e2 = (i % 3 == 0) ? e1 : EW'($urandom_range(0, 14));
            m1 = MW'($urandom_range(0, 255));
            m2 = (i % 7 == 0) ? m1 : MW'($urandom_range(0, 255));
            send(e1, m1, e2, m2);
            sb.push_back(model(e1, m1, e2, m2));
            wait_out(lat);
            e = sb.pop_front();
            checks++;
            if (lat !== e.lat || exp_o !== e.e || mant_o !== e.m || sign !== e.s || zero !== e.z) begin
                errors++;
                $display("FAIL rand%0d: got lat=%0d e=%0d m=%h s=%b z=%b, required lat=%0d e=%0d m=%h s=%b z=%b",
                         i, lat, exp_o, mant_o, sign, zero, e.lat, e.e, e.m, e.s, e.z);
            end
            consume();
        end
    endtask

    task automatic test_backpressure();
        res_t e;
        int lat;
        send(9'd5, 8'h80, 9'd7, 8'h80);
        sb.push_back(model(9'd5, 8'h80, 9'd7, 8'h80));
        wait_out(lat);
        e = sb.pop_front();
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || exp_o !== e.e ||
                mant_o !== e.m || sign !== e.s || zero !== e.z) begin
                errors++;
                $display("FAIL hold%0d: got v=%b r=%b e=%0d m=%h s=%b z=%b, required v=1 r=0 e=%0d m=%h s=%b z=%b",
                         c, out_valid, in_ready, exp_o, mant_o, sign, zero, e.e, e.m, e.s, e.z);
            end
            if (c < 3) begin
                @(posedge clk);
                #1;
            end
        end
        consume();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL release: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid();
        res_t e;
        int lat;
        send(9'd20, 8'h81, 9'd20, 8'h80);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || exp_o !== 9'd0 ||
            mant_o !== 8'd0 || sign !== 1'b0 || zero !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got r=%b v=%b e=%0d m=%h s=%b z=%b, required r=1 v=0 and zeros",
                     in_ready, out_valid, exp_o, mant_o, sign, zero);
        end
        send(9'd10, 8'hC0, 9'd10, 8'h80);
        sb.push_back(model(9'd10, 8'hC0, 9'd10, 8'h80));
        wait_out(lat);
        e = sb.pop_front();
        checks++;
        if (lat !== e.lat || exp_o !== e.e || mant_o !== e.m || sign !== e.s || zero !== e.z) begin
            errors++;
            $display("FAIL after_reset: got lat=%0d e=%0d m=%h s=%b, required lat=%0d e=%0d m=%h s=%b",
                     lat, exp_o, mant_o, sign, e.lat, e.e, e.m, e.s);
        end
        consume();
    endtask

    task automatic test_back_to_back();
        res_t e;
        int lat;
        send(9'd20, 8'h81, 9'd20, 8'h80);
        sb.push_back(model(9'd20, 8'h81, 9'd20, 8'h80));
        exp1 = 9'd8;
        mant1 = 8'h40;
        exp2 = 9'd9;
        mant2 = 8'hF0;
        in_valid = 1'b1;
        sb.push_back(model(9'd8, 8'h40, 9'd9, 8'hF0));
        wait_out(lat);
        e = sb.pop_front();
        checks++;
        if (lat !== e.lat || exp_o !== e.e || mant_o !== e.m || sign !== e.s || zero !== e.z) begin
            errors++;
            $display("FAIL b2b_first: got lat=%0d e=%0d m=%h s=%b, required lat=%0d e=%0d m=%h s=%b",
                     lat, exp_o, mant_o, sign, e.lat, e.e, e.m, e.s);
        end
        consume();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready: in_ready=%b, required 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_out(lat);
        e = sb.pop_front();
        checks++;
        if (lat !== e.lat || exp_o !== e.e || mant_o !== e.m || sign !== e.s || zero !== e.z) begin
            errors++;
            $display("FAIL b2b_second: got lat=%0d e=%0d m=%h s=%b, required lat=%0d e=%0d m=%h s=%b",
                     lat, exp_o, mant_o, sign, e.lat, e.e, e.m, e.s);
        end
        consume();
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/flp_subtractor.md
# flp_subtractor

Multi-cycle floating-point subtractor, the inverse of the pseudo-softmax FLP adder: computes |A − B| on operands in the same (exponent, mantissa) format, where value = mant × 2^exp with unsigned exp and an explicit unsigned significand. It removes an accumulated term from a running sum and normalizes the result iteratively. The block sits between the exponent/accumulator stage and the output divider. A valid/ready handshake on both sides isolates it from variable downstream latency.

## Interface
- EXP_WIDTH, 9, exponent width (unsigned)
- MANT_WIDTH, 8, mantissa width (explicit significand, normalized when MSB = 1)

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operands valid
- in_ready  out  1  block idle and able to accept operands
- exp1, mant1  in  EXP_WIDTH, MANT_WIDTH  operand A
- exp2, mant2  in  EXP_WIDTH, MANT_WIDTH  operand B
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- exp, mant  out  EXP_WIDTH, MANT_WIDTH  result magnitude
- sign  out  1  1 when B > A (result = B − A), else 0
- zero  out  1  result exactly zero

## Operation
- States: IDLE, ALIGN, SUB, NORM, DONE.
- IDLE: in_ready = 1. When in_valid is high, the block captures exp1/mant1/exp2/mant2 and moves to ALIGN.
- ALIGN (1 cycle):
  - Register max_exp = max(exp1, exp2).
  - Shift the mantissa of the smaller-exponent operand right by |exp1 − exp2|. Shifted-out bits are truncated. If the difference is ≥ MANT_WIDTH, the aligned mantissa is 0.
  - On equal exponents, neither mantissa shifts.
- SUB (1 cycle):
  - sign = (alignedB > alignedA).
  - diff = larger − smaller. No borrow is possible.
  - Register exp = max_exp. Go to NORM.
- NORM (one evaluation per cycle), checked in this order:
  - diff == 0: set mant = 0, exp = 0, sign = 0, zero = 1, then go to DONE.
  - mant MSB == 1, or exp == 0: go to DONE. Exponent floor: the result stays unnormalized.
  - Otherwise: mant <<= 1 (shift in 0), exp −= 1, stay in NORM.
- DONE: out_valid = 1. Outputs are held stable until out_ready is high, then the block goes to IDLE. in_ready = 0 in every state except IDLE.
- Width rules:
  - No exponent overflow is possible (result exp ≤ max_exp).
  - The exponent never wraps below 0.
  - The shift count k is at most MANT_WIDTH − 1.
- Reset: any state goes to IDLE at the next edge. A reset mid-operation discards the operation.

## Timing
- Reset values: in_ready = 1, out_valid = 0, exp = 0, mant = 0, sign = 0, zero = 0.
- Latency: handshake in cycle 0; out_valid rises in cycle 4 + k, where k is the number of normalization shifts (0..MANT_WIDTH−1).
- Throughput: one operation in flight. The next accept can happen in the cycle after the output handshake.
- Simultaneous events:
  - A new in_valid while busy is ignored. The source must hold its operands until in_ready.
  - out_ready asserted before out_valid has no effect.
  - rst overrides every handshake.

## Test plan
- A=(10,0xC0), B=(10,0x80) → exp=9, mant=0x80, sign=0, zero=0; out_valid in cycle 5.
- A=(5,0x80), B=(7,0x80): A aligns to 0x20, diff 0x60 → exp=6, mant=0xC0, sign=1; out_valid in cycle 5.
- A=B=(12,0xA5) → exp=0, mant=0, zero=1, sign=0; out_valid in cycle 4.
- A=(20,0x90), B=(3,0xFF): diff ≥ 8, so B aligns to 0 → exp=20, mant=0x90, sign=0; out_valid in cycle 4.
- A=(2,0x81), B=(2,0x80): floor case → exp=0, mant=0x04, sign=0; out_valid in cycle 6.
- Backpressure and reset:
  - Hold out_ready low for 3 cycles in DONE → outputs stable, in_ready=0.
  - Assert rst during NORM of a k=7 case → next cycle IDLE, out_valid=0, in_ready=1, all outputs 0.
  - A fresh operation afterwards completes correctly.
